// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Purpose  : Holds domain resets for a minimum width, releases them in index
//            order with a fixed stagger, and restarts on sw/wdt requests.
// Revision : 1.0  initial release
// ============================================================================
module reset_sequencer #(
  parameter int NUM_DOMAINS    = 4,
  parameter int ASSERT_CYCLES  = 16,
  parameter int STAGGER_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sw_req,
  input  logic                   wdt_req,
  output logic                   req_ack,
  output logic [NUM_DOMAINS-1:0] rst_n_out,
  output logic                   busy,
  output logic [1:0]             cause
);

  localparam int c_max_cycles = (ASSERT_CYCLES > STAGGER_CYCLES) ? ASSERT_CYCLES : STAGGER_CYCLES;
  localparam int CW = $clog2(c_max_cycles + 1);
  localparam int IW = $clog2(NUM_DOMAINS + 1);

  localparam logic [CW-1:0] c_assert_last  = CW'(ASSERT_CYCLES - 1);
  localparam logic [CW-1:0] c_stagger_last = CW'(STAGGER_CYCLES - 1);
  localparam logic [IW-1:0] c_idx_last     = IW'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [NUM_DOMAINS-1:0]  w_rel_mask;
  logic                    w_req;

  assign w_req = sw_req | wdt_req;

  // One-hot select of the domain that the current stagger step releases.
  for (genvar k = 0; k < NUM_DOMAINS; k++) begin : g_rel_mask
    assign w_rel_mask[k] = (r_idx == IW'(k));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_HOLD;
      r_cnt     <= '0;
      r_idx     <= '0;
      rst_n_out <= '0;
      busy      <= 1'b1;
      req_ack   <= 1'b0;
      cause     <= 2'b00;
    end else begin
      req_ack <= 1'b0;
      if ((r_state != S_HOLD) && w_req) begin
        // Requests abort any release in progress; HOLD deliberately ignores them
        // so every domain always sees the full assertion width.
        req_ack   <= 1'b1;
        cause     <= {wdt_req, sw_req};
        rst_n_out <= '0;
        busy      <= 1'b1;
        r_cnt     <= '0;
        r_idx     <= '0;
        r_state   <= S_HOLD;
      end else begin
        case (r_state)
          S_HOLD: begin
            if (r_cnt == c_assert_last) begin
              rst_n_out[0] <= 1'b1;
              r_cnt        <= '0;
              if (NUM_DOMAINS == 1) begin
                busy    <= 1'b0;
                r_state <= S_RUN;
              end else begin
                r_idx   <= IW'(1);
                r_state <= S_RELEASE;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_RELEASE: begin
            if (r_cnt == c_stagger_last) begin
              rst_n_out <= rst_n_out | w_rel_mask;
              r_cnt     <= '0;
              if (r_idx == c_idx_last) begin
                busy    <= 1'b0;
                r_state <= S_RUN;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_RUN: begin
            busy <= 1'b0;
          end
          default: begin
            rst_n_out <= '0;
            busy      <= 1'b1;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_state   <= S_HOLD;
          end
        endcase
      end
    end
  end

`ifndef SYNTHESIS
  a_busy_matches : assert property (@(posedge clk) disable iff (!rst)
    busy == ~&rst_n_out);
  a_ack_clears   : assert property (@(posedge clk) disable iff (!rst)
    req_ack |-> (rst_n_out == '0));
  for (genvar k = 1; k < NUM_DOMAINS; k++) begin : g_order_chk
    a_in_order : assert property (@(posedge clk) disable iff (!rst)
      rst_n_out[k] |-> rst_n_out[k-1]);
  end
`endif

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
# reset_sequencer

Reset-side controller that drives the active-low resets for several downstream clock-synchronous domains. It takes the board reset, already synchronized for deassertion, plus software and watchdog reset requests. It holds all domain resets asserted for a guaranteed minimum width, then releases them one at a time in index order with a fixed stagger. It records the cause of the most recent reset and acknowledges each accepted request with a one-cycle pulse.

## Interface
Parameters:
- NUM_DOMAINS, 4, number of downstream domain resets; legal range ≥1.
- ASSERT_CYCLES, 16, minimum number of cycles all domain resets stay asserted; legal range ≥1.
- STAGGER_CYCLES, 8, number of cycles between successive domain releases; legal range ≥1.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-low reset. Assertion takes effect immediately; deassertion is already synchronized to clk upstream.
- sw_req  in  1  software reset request; level, held high by the requester until req_ack.
- wdt_req  in  1  watchdog reset request; level, same rules as sw_req.
- req_ack  out  1  one-cycle pulse marking an accepted request.
- rst_n_out  out  NUM_DOMAINS  active-low domain resets. Bit k is released in order k.
- busy  out  1  high while any rst_n_out bit is asserted (low).
- cause  out  2  cause of the last reset: 00 = POR/rst, 01 = sw, 10 = wdt, 11 = sw and wdt together.

## Operation
- FSM states: HOLD, RELEASE, RUN. All outputs are registered.
- Reset (rst low) forces the following immediately:
  - state = HOLD, cnt = 0, idx = 0
  - rst_n_out = all 0, busy = 1, req_ack = 0, cause = 00
- Internal counter cnt has width $clog2(max(ASSERT_CYCLES, STAGGER_CYCLES)+1). idx has width $clog2(NUM_DOMAINS+1).
- HOLD:
  - All rst_n_out bits stay 0 and cnt increments each cycle.
  - When cnt == ASSERT_CYCLES-1: set rst_n_out[0] = 1 and cnt = 0.
  - If NUM_DOMAINS == 1, go to RUN with busy = 0; otherwise go to RELEASE with idx = 1.
  - sw_req and wdt_req are ignored in HOLD: no ack, no cause update. The requester keeps holding its request.
- RELEASE:
  - cnt increments each cycle.
  - When cnt == STAGGER_CYCLES-1: set rst_n_out[idx] = 1 and cnt = 0.
  - If idx == NUM_DOMAINS-1, go to RUN with busy = 0; otherwise increment idx.
  - A request sampled in RELEASE is accepted (see below) and aborts the sequence.
- RUN: all rst_n_out bits are 1 and busy = 0. The block waits for a request.
- Request acceptance (RELEASE or RUN, sw_req | wdt_req sampled high at an edge). At that same edge:
  - req_ack = 1 for exactly one cycle
  - cause = {wdt_req, sw_req}
  - rst_n_out = all 0, busy = 1, cnt = 0, idx = 0
  - state = HOLD
- A request still high after its ack is ignored, because the block is then in HOLD. The requester must drop the request on seeing req_ack. A request still high once the block leaves HOLD is accepted again.
- Released bits never drop except on request acceptance or rst. Bits are never released out of index order.

## Timing
- Let edge 0 be the last edge with rst low and edge 1 the first edge with rst high.
  - rst_n_out[0] rises at edge ASSERT_CYCLES.
  - rst_n_out[k] rises at edge ASSERT_CYCLES + k·STAGGER_CYCLES.
  - busy falls together with the last bit.
- Request accepted at edge E:
  - req_ack is high from edge E to edge E+1.
  - rst_n_out is all 0 from edge E.
  - rst_n_out[0] rises at edge E+ASSERT_CYCLES.
- Minimum assertion width for every domain is ASSERT_CYCLES cycles, regardless of when a request arrives.
- rst asserted mid-HOLD, mid-RELEASE or mid-RUN: outputs go to their reset values asynchronously, without waiting for clk, and cause returns to 00.

## Test plan
- POR (NUM_DOMAINS=3, ASSERT_CYCLES=4, STAGGER_CYCLES=2), rst low for 5 cycles, then high:
  - while rst is low: rst_n_out=000, busy=1, cause=00, req_ack=0
  - after release: bit0 rises at edge 4, bit1 at edge 6, bit2 at edge 8; busy falls at edge 8
- sw_req held high in RUN until ack:
  - req_ack high for exactly 1 cycle, cause=01, rst_n_out=000 from the accept edge
  - bits re-release at edges +4, +6, +8
- sw_req and wdt_req rise in the same cycle in RUN → a single req_ack, cause=11.
- wdt_req raised during HOLD:
  - no ack while in HOLD
  - ack at the first RELEASE edge, cause=10, rst_n_out[0] drops back to 0, and the sequence restarts
- wdt_req at the edge where bit1 would rise (RELEASE, idx=1) → bit1 stays 0, bit0 drops, and a full 4-cycle HOLD restarts.
- rst pulsed low mid-RELEASE after a wdt reset (cause=10) → asynchronous return to all-0 and cause=00, then a full POR sequence.
